// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: load-use stall, branch flush and PC-source control, plus interrupt
// entry/return sequencing. The interrupt logic is built only when PPL_IRQ_EN is defined.
module pipeline_ctrl #(
   parameter int          IRQ_N    = 4,
   parameter logic [15:0] VEC_BASE = 16'h0010,
   parameter bit          IE_RST   = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IRQ_N-1:0] irq,
   input  logic             id_valid,
   input  logic [2:0]       id_rd,
   input  logic [2:0]       id_rs,
   input  logic [15:0]      id_pc,
   input  logic             id_reti,
   input  logic             ex_load,
   input  logic [2:0]       ex_rd,
   input  logic             ex_branch_taken,
   output logic             stall,
   output logic             flush_ifid,
   output logic             flush_idex,
   output logic [1:0]       pc_sel,
   output logic [15:0]      vec_addr,
   output logic [15:0]      epc,
   output logic [IRQ_N-1:0] irq_ack,
   output logic             in_isr
);
   logic w_hazard;

   // ALU operations read rd as a source, so both fields are compared.
   assign w_hazard = id_valid & ex_load & ((ex_rd == id_rs) | (ex_rd == id_rd));

`ifdef PPL_IRQ_EN
   typedef enum logic [1:0] {
      S_RUN    = 2'b00,
      S_ENTER  = 2'b01,
      S_ISR    = 2'b10,
      S_RETURN = 2'b11
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_gie;
   logic [IRQ_N-1:0] r_pend;
   logic [15:0]      r_epc;
   logic [15:0]      r_vec_addr;
   logic [IRQ_N-1:0] r_irq_ack;
   logic [2:0]       w_irq_id;
   logic [IRQ_N-1:0] w_onehot;
   logic [IRQ_N-1:0] w_clr;
   logic             w_take;
   logic             w_stall;
   logic             w_flush_ifid;
   logic             w_flush_idex;
   logic [1:0]       w_pc_sel;

   // Priority select: scanning downwards leaves the lowest-index pending bit.
   always_comb begin
      w_irq_id = 3'd0;
      for (int i = IRQ_N - 1; i >= 0; i--) begin
         w_irq_id = r_pend[i] ? 3'(i) : w_irq_id;
      end
      for (int i = 0; i < IRQ_N; i++) begin
         w_onehot[i] = (w_irq_id == 3'(i));
      end
   end

   assign w_clr = w_take ? w_onehot : {IRQ_N{1'b0}};

   // Next state and same-cycle pipeline controls.
   always_comb begin
      w_state_nxt  = r_state;
      w_stall      = 1'b0;
      w_flush_ifid = 1'b0;
      w_flush_idex = 1'b0;
      w_pc_sel     = 2'b00;
      w_take       = 1'b0;
      case (r_state)
         S_RUN, S_ISR: begin
            if (ex_branch_taken) begin
               w_pc_sel     = 2'b01;
               w_flush_ifid = 1'b1;
               w_flush_idex = 1'b1;
            end else if (w_hazard) begin
               w_stall      = 1'b1;
               w_flush_idex = 1'b1;
            end else if ((r_state == S_RUN) && r_gie && (|r_pend) && id_valid && !id_reti) begin
               w_take       = 1'b1;
               w_flush_ifid = 1'b1;
               w_flush_idex = 1'b1;
               w_state_nxt  = S_ENTER;
            end else if ((r_state == S_ISR) && id_reti && id_valid) begin
               w_flush_ifid = 1'b1;
               w_flush_idex = 1'b1;
               w_state_nxt  = S_RETURN;
            end else begin
               w_state_nxt  = r_state;
            end
         end
         S_ENTER: begin
            w_pc_sel     = 2'b10;
            w_flush_ifid = 1'b1;
            w_state_nxt  = S_ISR;
         end
         S_RETURN: begin
            w_pc_sel     = 2'b11;
            w_flush_ifid = 1'b1;
            w_state_nxt  = S_RUN;
         end
         default: begin
            w_state_nxt  = S_RUN;
         end
      endcase
   end

   // Sequencer state, pending capture (set wins over clear) and entry bookkeeping.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_RUN;
         r_gie      <= IE_RST;
         r_pend     <= {IRQ_N{1'b0}};
         r_epc      <= 16'h0000;
         r_vec_addr <= VEC_BASE;
         r_irq_ack  <= {IRQ_N{1'b0}};
      end else begin
         r_state   <= w_state_nxt;
         r_pend    <= (r_pend & ~w_clr) | irq;
         r_irq_ack <= w_clr;
         if (w_take) begin
            r_epc      <= id_pc;
            r_vec_addr <= VEC_BASE + {11'd0, w_irq_id, 2'b00};
            r_gie      <= 1'b0;
         end else if (r_state == S_RETURN) begin
            r_gie      <= 1'b1;
         end else begin
            r_gie      <= r_gie;
         end
      end
   end

   assign stall      = w_stall;
   assign flush_ifid = w_flush_ifid;
   assign flush_idex = w_flush_idex;
   assign pc_sel     = w_pc_sel;
   assign vec_addr   = r_vec_addr;
   assign epc        = r_epc;
   assign irq_ack    = r_irq_ack;
   assign in_isr     = (r_state == S_ENTER) | (r_state == S_ISR);
`else
   logic w_unused;

   assign w_unused = ^{clk, rst_n, irq, id_pc, id_reti, IE_RST};

   // Hazard and branch handling only; a taken branch overrides the stall.
   always_comb begin
      stall      = 1'b0;
      flush_ifid = 1'b0;
      flush_idex = 1'b0;
      pc_sel     = 2'b00;
      if (ex_branch_taken) begin
         pc_sel     = 2'b01;
         flush_ifid = 1'b1;
         flush_idex = 1'b1;
      end else if (w_hazard) begin
         stall      = 1'b1;
         flush_idex = 1'b1;
      end else begin
         stall      = 1'b0;
      end
   end

   assign vec_addr = VEC_BASE;
   assign epc      = 16'h0000;
   assign irq_ack  = {IRQ_N{1'b0}};
   assign in_isr   = 1'b0;
`endif
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and interrupt sequencer for the 16-bit pipelined core. It sits beside the decode stage and consumes the decoder's register fields and the EX-stage status. It generates stall and flush controls for the IF/ID and ID/EX pipeline registers, and the PC source select. It also owns interrupt pending capture, priority selection, EPC save and the entry/return sequencing.

## Interface
- `IRQ_N`, default 4: number of interrupt request lines, range 1..8.
- `VEC_BASE`, default 16'h0010: address of the vector for IRQ 0.
- `IE_RST`, default 1: reset value of the global interrupt enable.
- `clk`, input, 1: core clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `irq`, input, IRQ_N: request pulses, one cycle each, latched into pending.
- `id_valid`, input, 1: the ID stage holds a real instruction (not a bubble).
- `id_rd`, input, 3: ID-stage rd field, inst[7:5].
- `id_rs`, input, 3: ID-stage rs field, inst[10:8].
- `id_pc`, input, 16: PC of the ID-stage instruction.
- `id_reti`, input, 1: the ID-stage instruction is RETI.
- `ex_load`, input, 1: the EX-stage instruction is LW (RegWe & RWSel).
- `ex_rd`, input, 3: rd of the EX-stage instruction.
- `ex_branch_taken`, input, 1: the BEQ/BLE in EX resolved taken.
- `stall`, output, 1: hold PC and IF/ID; inject a bubble into ID/EX.
- `flush_ifid`, output, 1: the IF/ID register loads a bubble.
- `flush_idex`, output, 1: the ID/EX register loads a bubble.
- `pc_sel`, output, 2: PC source. 00 = PC+1, 01 = branch target, 10 = vec_addr, 11 = epc.
- `vec_addr`, output, 16: registered, VEC_BASE + {irq_id, 2'b00}.
- `epc`, output, 16: registered saved return PC.
- `irq_ack`, output, IRQ_N: registered one-hot, one cycle, marks the serviced line.
- `in_isr`, output, 1: high while in the ENTER or ISR state.

## Operation
- Pending register `pend[IRQ_N-1:0]`: `pend <= (pend & ~clr) | irq`. If a bit is set and cleared in the same cycle, set wins.
- Priority: the lowest-index pending bit wins. `irq_id` is 3 bits, zero-extended into vec_addr.
- Load-use hazard: `stall = id_valid & ex_load & (ex_rd==id_rs | ex_rd==id_rd)`. Both rd and rs are compared because ALU operations read rd.
  - stall forces flush_idex=1 and pc_sel=00 with the PC held.
  - stall is suppressed whenever ex_branch_taken=1.
- Branch: ex_branch_taken=1 gives pc_sel=01, flush_ifid=1, flush_idex=1, stall=0. It has the highest priority in the RUN and ISR states.
- State machine, with states RUN, ENTER, ISR and RETURN:
  - **RUN.** Interrupt entry is taken when all of the following hold: gie=1, |pend, id_valid=1, stall=0, ex_branch_taken=0, id_reti=0. On entry:
    - Drive flush_ifid=1 and flush_idex=1. The ID instruction is dropped and later re-executed.
    - Register epc<=id_pc, vec_addr, irq_ack<=onehot(irq_id); clear that pend bit; set gie<=0.
    - Go to ENTER.
  - **ENTER** (1 cycle): pc_sel=10, flush_ifid=1 (drops the sequential fetch), then go to ISR. ex_branch_taken is ignored because EX holds a bubble.
  - **ISR:** hazard and branch handling are identical to RUN, with no nesting. id_reti & id_valid & ~stall & ~ex_branch_taken gives flush_ifid=1 and flush_idex=1, then go to RETURN.
  - **RETURN** (1 cycle): pc_sel=11, flush_ifid=1, gie<=1, then go to RUN.
- id_reti seen in the RUN state is treated as a NOP: no flush, no PC change.

## Timing
- Reset values:
  - state=RUN, gie=IE_RST, pend=0, epc=0, vec_addr=VEC_BASE, irq_ack=0.
  - Combinational outputs settle to stall=0, flush_*=0, pc_sel=00.
- stall, flush_ifid, flush_idex and pc_sel are combinational from the current inputs and state, and valid in the same cycle.
- Interrupt latency:
  - irq pulse in cycle N → pend set at N+1.
  - Earliest entry decision at N+1 → ENTER at N+2 (vector fetched) → first ISR instruction reaches ID at N+3.
- Entry costs 2 bubbles and return costs 2 bubbles. A load-use stall costs 1 bubble per occurrence. A taken branch costs 2 bubbles.
- Reset asserted mid-sequence (ENTER, ISR or RETURN) returns to RUN with gie=IE_RST, and pending requests are lost.

## Configuration
- `PPL_IRQ_EN` defined: full interrupt logic as above.
- `PPL_IRQ_EN` undefined:
  - The state machine, pend, epc, vec_addr and gie are removed.
  - irq_ack=0, in_isr=0, epc=0, vec_addr=VEC_BASE.
  - pc_sel is only ever 00 or 01. id_reti is ignored.
  - Only load-use stall and branch flush remain.

## Test plan
- Load-use: ex_load=1, ex_rd=3, id_rs=3 → stall=1, flush_idex=1 for exactly 1 cycle. The same case with ex_rd=5, id_rs=3, id_rd=2 → stall=0.
- Branch over stall: ex_load=1 hazard plus ex_branch_taken=1 in the same cycle → stall=0, pc_sel=01, flush_ifid=flush_idex=1.
- Interrupt entry: IRQ_N=4, irq=4'b0110 pulse with id_pc=16'h0042 →
  - epc=16'h0042 and irq_ack=4'b0010 one cycle later.
  - Next cycle pc_sel=10 with vec_addr=16'h0014.
  - pend retains 4'b0100.
- Blocked entry: a pending irq coinciding with a stall or a taken branch → no entry that cycle; entry occurs on the first cycle both are clear.
- Return: in ISR, id_reti=1 → RETURN with pc_sel=11, epc=16'h0042, in_isr=0 after. The pending bit 2 is then taken (vec_addr=16'h0018).
- Reset mid-ISR: rst_n=0 for 1 cycle while in ISR → state=RUN, gie=1, pend=0, irq_ack=0, pc_sel=00.
